// File: rtl/mem_channel_arbiter.sv
// ----------------------------------------------------------------------------
// mem_channel_arbiter
//
// Shares one data-memory channel (one read port plus one write port) among
// NUM_CONSUMERS per-thread LSUs. Arbitration is round-robin and only one
// transaction is in flight at a time. Both sides use a valid/ready
// hold-until-ack handshake:
//   - A consumer holds *_valid until it sees its *_ready.
//   - The arbiter then holds *_ready until that consumer drops *_valid.
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   consumer_read_valid[c]      read request from consumer c
//   consumer_read_address[c]    read address from consumer c
//   consumer_read_ready[c]      read done; consumer_read_data[c] is valid
//   consumer_read_data[c]       last data read for consumer c
//   consumer_write_valid[c]     write request from consumer c
//   consumer_write_address[c]   write address from consumer c
//   consumer_write_data[c]      write data from consumer c
//   consumer_write_ready[c]     write done
//   mem_read_valid/address      read request to memory
//   mem_read_ready/data         read acknowledge and data from memory
//   mem_write_valid/address/data  write request to memory
//   mem_write_ready             write acknowledge from memory
//   busy                        high whenever the FSM is not idle
// All outputs are registered.
// ----------------------------------------------------------------------------
module mem_channel_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],

  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,

  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,

  output logic                     busy
);

  localparam int IDX_BITS = $clog2(NUM_CONSUMERS);

  localparam logic [1:0] IDLE          = 2'd0;
  localparam logic [1:0] READ_WAITING  = 2'd1;
  localparam logic [1:0] WRITE_WAITING = 2'd2;
  localparam logic [1:0] RELAYING      = 2'd3;

  logic [1:0]          state;
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] grant;
  // Remembers which handshake is being relayed, so RELAYING watches the
  // matching valid of the granted consumer.
  logic                relay_is_read;

  // Round-robin winner search, starting at rr_ptr. NUM_CONSUMERS is a power
  // of two, so the IDX_BITS-wide sum wraps modulo NUM_CONSUMERS by itself.
  logic                win_found;
  logic [IDX_BITS-1:0] win_idx;
  logic                win_read;
  logic [IDX_BITS-1:0] cand;

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_read  = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = rr_ptr + IDX_BITS'(i);
      if (!win_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        win_found = 1'b1;
        win_idx   = cand;
        // If a consumer requests both, the read goes first. The write stays
        // pending and is served in a later grant.
        win_read  = consumer_read_valid[cand];
      end
    end
  end

  // The relay ends once the granted consumer drops the valid being answered.
  logic relay_done;
  assign relay_done = relay_is_read ? !consumer_read_valid[grant]
                                    : !consumer_write_valid[grant];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and simulation matches hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      relay_is_read        <= 1'b0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      busy                 <= 1'b0;
      // NOTE: the read-data registers are reset as well, even though they are
      // data storage. The LSUs must see defined zeros after reset.
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        consumer_read_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_idx;
            busy  <= 1'b1;
            if (win_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[win_idx];
              state            <= READ_WAITING;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[win_idx];
              mem_write_data    <= consumer_write_data[win_idx];
              state             <= WRITE_WAITING;
            end
          end
        end

        // Address and data were latched at grant time. They stay stable even
        // if the requester misbehaves and drops valid while waiting.
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid             <= 1'b0;
            consumer_read_data[grant]  <= mem_read_data;
            consumer_read_ready[grant] <= 1'b1;
            relay_is_read              <= 1'b1;
            state                      <= RELAYING;
          end
        end

        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            relay_is_read               <= 1'b0;
            state                       <= RELAYING;
          end
        end

        RELAYING: begin
          // No new grant on this edge. The next grant starts from IDLE.
          if (relay_done) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            rr_ptr               <= grant + 1'b1;
            busy                 <= 1'b0;
            state                <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_channel_arbiter
//
// Directed testbench for mem_channel_arbiter (4 consumers, 8-bit address and
// data). The bench plays the memory by hand: it waits for a request, checks
// the request, then acknowledges after a chosen delay. Expected addresses,
// data and grant order are written out as constants in each step.
// ----------------------------------------------------------------------------
module tb_mem_channel_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] consumer_read_valid;
  logic [7:0]   consumer_read_address  [N];
  logic [N-1:0] consumer_read_ready;
  logic [7:0]   consumer_read_data     [N];
  logic [N-1:0] consumer_write_valid;
  logic [7:0]   consumer_write_address [N];
  logic [7:0]   consumer_write_data    [N];
  logic [N-1:0] consumer_write_ready;
  logic         mem_read_valid;
  logic [7:0]   mem_read_address;
  logic         mem_read_ready;
  logic [7:0]   mem_read_data;
  logic         mem_write_valid;
  logic [7:0]   mem_write_address;
  logic [7:0]   mem_write_data;
  logic         mem_write_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_channel_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one read for consumer c. The consumer's read valid must already be
  // set. The ack comes after `delay` idle cycles. The consumer then keeps
  // valid for `hold` extra cycles before dropping it.
  task automatic serve_read(input int c, input logic [7:0] addr, input logic [7:0] data,
                            input int delay, input int hold, input string tag);
    int n = 0;
    while (!mem_read_valid && n < 20) begin tick(); n++; end
    check({tag, "_rvalid"},    mem_read_valid, 1);
    check({tag, "_raddr"},     mem_read_address, addr);
    check({tag, "_no_wvalid"}, mem_write_valid, 0);
    check({tag, "_busy"},      busy, 1);
    repeat (delay) tick();
    check({tag, "_no_ready_early"}, consumer_read_ready, 0);
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = 8'h00;
    check({tag, "_rvalid_drop"}, mem_read_valid, 0);
    check({tag, "_rready"},      consumer_read_ready, 32'(1 << c));
    check({tag, "_rdata"},       consumer_read_data[c], data);
    check({tag, "_no_wready"},   consumer_write_ready, 0);
    repeat (hold) begin
      tick();
      check({tag, "_rready_held"}, consumer_read_ready, 32'(1 << c));
    end
    consumer_read_valid[c] = 1'b0;
    tick();
    check({tag, "_rready_drop"}, consumer_read_ready, 0);
    check({tag, "_idle"},        busy, 0);
  endtask

  task automatic serve_write(input int c, input logic [7:0] addr, input logic [7:0] data,
                             input string tag);
    int n = 0;
    while (!mem_write_valid && n < 20) begin tick(); n++; end
    check({tag, "_wvalid"},    mem_write_valid, 1);
    check({tag, "_waddr"},     mem_write_address, addr);
    check({tag, "_wdata"},     mem_write_data, data);
    check({tag, "_no_rvalid"}, mem_read_valid, 0);
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    check({tag, "_wvalid_drop"}, mem_write_valid, 0);
    check({tag, "_wready"},      consumer_write_ready, 32'(1 << c));
    check({tag, "_no_rready"},   consumer_read_ready, 0);
    consumer_write_valid[c] = 1'b0;
    tick();
    check({tag, "_wready_drop"}, consumer_write_ready, 0);
    check({tag, "_idle"},        busy, 0);
  endtask

  initial begin
    reset                = 1'b1;
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    for (int i = 0; i < N; i++) begin
      consumer_read_address[i]  = 8'h00;
      consumer_write_address[i] = 8'h00;
      consumer_write_data[i]    = 8'h00;
    end
    mem_read_ready  = 1'b0;
    mem_read_data   = 8'h00;
    mem_write_ready = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_mem_rvalid", mem_read_valid, 0);
    check("rst_mem_wvalid", mem_write_valid, 0);
    check("rst_rready",     consumer_read_ready, 0);
    check("rst_wready",     consumer_write_ready, 0);
    check("rst_busy",       busy, 0);
    check("rst_rdata2",     consumer_read_data[2], 0);
    reset = 1'b0;
    tick();

    // Fairness from reset: all four consumers read at once, so the order is
    // 0,1,2,3 and rr_ptr ends at 0.
    for (int i = 0; i < N; i++) consumer_read_address[i] = 8'hA0 + 8'(i);
    consumer_read_valid = 4'b1111;
    serve_read(0, 8'hA0, 8'hC0, 0, 0, "rr0_c0");
    serve_read(1, 8'hA1, 8'hC1, 1, 0, "rr0_c1");
    serve_read(2, 8'hA2, 8'hC2, 0, 0, "rr0_c2");
    serve_read(3, 8'hA3, 8'hC3, 2, 0, "rr0_c3");

    // Mixed: consumer 0 writes and consumer 3 reads. With rr_ptr = 0 the
    // write goes first. Consumer 0's read data must stay 0xC0.
    consumer_write_address[0] = 8'h20;
    consumer_write_data[0]    = 8'h11;
    consumer_write_valid[0]   = 1'b1;
    consumer_read_address[3]  = 8'h30;
    consumer_read_valid[3]    = 1'b1;
    serve_write(0, 8'h20, 8'h11, "mix_w0");
    serve_read(3, 8'h30, 8'h77, 0, 0, "mix_r3");
    check("mix_rdata0_kept", consumer_read_data[0], 8'hC0);

    // Single read by consumer 2: the request shows up one edge later. The ack
    // comes 3 cycles later, and ready is held while valid stays up.
    // Afterwards rr_ptr = 3.
    consumer_read_address[2] = 8'h10;
    consumer_read_valid[2]   = 1'b1;
    tick();
    check("single_latency", mem_read_valid, 1);
    serve_read(2, 8'h10, 8'hA5, 3, 2, "single_c2");
    check("single_rdata1_kept", consumer_read_data[1], 8'hC1);

    // Fairness with rr_ptr = 3: the order is 3,0,1,2.
    for (int i = 0; i < N; i++) consumer_read_address[i] = 8'hB0 + 8'(i);
    consumer_read_valid = 4'b1111;
    serve_read(3, 8'hB3, 8'hD3, 0, 0, "rr3_c3");
    serve_read(0, 8'hB0, 8'hD0, 0, 0, "rr3_c0");
    serve_read(1, 8'hB1, 8'hD1, 0, 0, "rr3_c1");
    serve_read(2, 8'hB2, 8'hD2, 0, 0, "rr3_c2");

    // Consumer 1 requests a read and a write together: the read goes first,
    // then the write in a later grant.
    consumer_read_address[1]  = 8'h04;
    consumer_write_address[1] = 8'h08;
    consumer_write_data[1]    = 8'h5A;
    consumer_read_valid[1]    = 1'b1;
    consumer_write_valid[1]   = 1'b1;
    serve_read(1, 8'h04, 8'h3C, 1, 0, "rw_r1");
    serve_write(1, 8'h08, 8'h5A, "rw_w1");

    // Stall: the memory withholds the ack for 20 cycles. The request must stay
    // stable and no ready may appear. After this, rr_ptr = 3.
    consumer_read_address[2] = 8'h55;
    consumer_read_valid[2]   = 1'b1;
    tick();
    check("stall_grant", mem_read_valid, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("stall_rvalid", mem_read_valid, 1);
      check("stall_raddr",  mem_read_address, 8'h55);
      check("stall_ready",  consumer_read_ready, 0);
    end
    serve_read(2, 8'h55, 8'h99, 0, 0, "stall_c2");

    // Reset mid-operation. With rr_ptr = 3, consumer 3 is granted first.
    // Asserting reset in READ_WAITING clears the outputs at once. After
    // release, rr_ptr = 0, so consumer 1 wins over consumer 3.
    consumer_read_address[1] = 8'h41;
    consumer_read_address[3] = 8'h43;
    consumer_read_valid[1]   = 1'b1;
    consumer_read_valid[3]   = 1'b1;
    tick();
    check("rstmid_grant3", mem_read_address, 8'h43);
    #2 reset = 1'b1;
    #1;
    check("rstmid_rvalid", mem_read_valid, 0);
    check("rstmid_raddr",  mem_read_address, 0);
    check("rstmid_busy",   busy, 0);
    check("rstmid_rdata3", consumer_read_data[3], 0);
    tick();
    reset = 1'b0;
    tick();
    check("rstmid_grant1", mem_read_valid, 1);
    serve_read(1, 8'h41, 8'h61, 0, 0, "post_rst_c1");
    serve_read(3, 8'h43, 8'h63, 0, 0, "post_rst_c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
